// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register of a five-stage MIPS-style pipeline, together with
// the EX-side operand forwarding muxes and the load-use hazard detector.
//
// Ports
//   clk, rst_n            single clock, asynchronous active-low reset
//   ID_*                  decoded instruction fields and controls from ID
//   Flush                 squash the instruction entering EX (taken branch/jump)
//   EXMEM_*               forwarding source 1 (newest result)
//   MEMWB_*               forwarding source 2 (older result / load data)
//   ALU_In1, ALU_In2      ALU operands after forwarding and operand select
//   ALU_Control           registered ALU opcode
//                         (1 ADD, 2 SUB, 3 SLL, 4 SRL, 5 AND, 6 OR, 7 NOR,
//                          8 SLTU, 9 SLT; 0 means bubble)
//   EX_StoreData          forwarded rt value for stores
//   EX_Rd                 registered destination register
//   EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg
//                         registered controls
//   Stall                 combinational load-use hazard
//
// Flow control: this stage has no valid/ready pair. EX_Valid marks a real
// instruction in EX. Stall=1 tells upstream to hold PC and IF/ID for the
// current cycle; on that same edge this stage loads a bubble, so the held
// instruction enters EX one cycle later. A bubble is also loaded when Flush=1
// or ID_Valid=0. A bubble clears every control and data register.
// -----------------------------------------------------------------------------
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        ID_Valid,
    input  logic [31:0] ID_ReadData1,
    input  logic [31:0] ID_ReadData2,
    input  logic [31:0] ID_SignExtImm,
    input  logic [4:0]  ID_Shamt,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic [4:0]  ID_Rd,
    input  logic [3:0]  ID_ALU_Control,
    input  logic        ID_ALUSrc,
    input  logic        ID_ShiftSrc,
    input  logic        ID_RegDst,
    input  logic        ID_RegWrite,
    input  logic        ID_MemRead,
    input  logic        ID_MemWrite,
    input  logic        ID_MemToReg,

    input  logic        Flush,

    input  logic        EXMEM_RegWrite,
    input  logic [4:0]  EXMEM_Rd,
    input  logic [31:0] EXMEM_ALU_Result,
    input  logic        MEMWB_RegWrite,
    input  logic [4:0]  MEMWB_Rd,
    input  logic [31:0] MEMWB_WriteData,

    output logic [31:0] ALU_In1,
    output logic [31:0] ALU_In2,
    output logic [3:0]  ALU_Control,
    output logic [31:0] EX_StoreData,
    output logic [4:0]  EX_Rd,
    output logic        EX_Valid,
    output logic        EX_RegWrite,
    output logic        EX_MemRead,
    output logic        EX_MemWrite,
    output logic        EX_MemToReg,
    output logic        Stall
);

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic        ex_valid;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_memtoreg;
    logic        ex_alusrc;
    logic        ex_shiftsrc;
    logic [3:0]  ex_alu_control;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_shamt;
    logic [31:0] ex_read_data1;
    logic [31:0] ex_read_data2;
    logic [31:0] ex_imm;

    logic        stall;
    logic        load_bubble;

    // Load-use hazard: a load in EX whose destination is a source of the
    // instruction in ID. The bubble it inserts clears ex_valid, so the
    // condition drops after exactly one cycle. Flush does not gate it.
    always_comb begin
        stall = ex_valid && ex_memread && (ex_rd != 5'd0) && ID_Valid &&
                ((ex_rd == ID_Rs) || (ex_rd == ID_Rt));
    end

    assign load_bubble = stall || Flush || !ID_Valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid       <= 1'b0;
            ex_regwrite    <= 1'b0;
            ex_memread     <= 1'b0;
            ex_memwrite    <= 1'b0;
            ex_memtoreg    <= 1'b0;
            ex_alusrc      <= 1'b0;
            ex_shiftsrc    <= 1'b0;
            ex_alu_control <= 4'd0;
            ex_rd          <= 5'd0;
            ex_rs          <= 5'd0;
            ex_rt          <= 5'd0;
            ex_shamt       <= 5'd0;
            ex_read_data1  <= 32'd0;
            ex_read_data2  <= 32'd0;
            ex_imm         <= 32'd0;
        end else if (load_bubble) begin
            // rs/rt are cleared too, so a bubble can never match a
            // forwarding source (register 0 is never forwarded).
            ex_valid       <= 1'b0;
            ex_regwrite    <= 1'b0;
            ex_memread     <= 1'b0;
            ex_memwrite    <= 1'b0;
            ex_memtoreg    <= 1'b0;
            ex_alusrc      <= 1'b0;
            ex_shiftsrc    <= 1'b0;
            ex_alu_control <= 4'd0;
            ex_rd          <= 5'd0;
            ex_rs          <= 5'd0;
            ex_rt          <= 5'd0;
            ex_shamt       <= 5'd0;
            ex_read_data1  <= 32'd0;
            ex_read_data2  <= 32'd0;
            ex_imm         <= 32'd0;
        end else begin
            ex_valid       <= 1'b1;
            ex_regwrite    <= ID_RegWrite;
            ex_memread     <= ID_MemRead;
            ex_memwrite    <= ID_MemWrite;
            ex_memtoreg    <= ID_MemToReg;
            ex_alusrc      <= ID_ALUSrc;
            ex_shiftsrc    <= ID_ShiftSrc;
            ex_alu_control <= ID_ALU_Control;
            ex_rd          <= ID_RegDst ? ID_Rd : ID_Rt;
            ex_rs          <= ID_Rs;
            ex_rt          <= ID_Rt;
            ex_shamt       <= ID_Shamt;
            ex_read_data1  <= ID_ReadData1;
            ex_read_data2  <= ID_ReadData2;
            ex_imm         <= ID_SignExtImm;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding: EX/MEM is checked first because it holds the newer
    // result when both later stages write the same register.
    // ------------------------------------------------------------------
    logic        exmem_fwd_a;
    logic        exmem_fwd_b;
    logic        memwb_fwd_a;
    logic        memwb_fwd_b;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;

    always_comb begin
        exmem_fwd_a = EXMEM_RegWrite && (EXMEM_Rd != 5'd0) && (EXMEM_Rd == ex_rs);
        exmem_fwd_b = EXMEM_RegWrite && (EXMEM_Rd != 5'd0) && (EXMEM_Rd == ex_rt);
        memwb_fwd_a = MEMWB_RegWrite && (MEMWB_Rd != 5'd0) && (MEMWB_Rd == ex_rs);
        memwb_fwd_b = MEMWB_RegWrite && (MEMWB_Rd != 5'd0) && (MEMWB_Rd == ex_rt);
    end

    always_comb begin
        fwd_a = ex_read_data1;
        if (exmem_fwd_a) begin
            fwd_a = EXMEM_ALU_Result;
        end else if (memwb_fwd_a) begin
            fwd_a = MEMWB_WriteData;
        end

        fwd_b = ex_read_data2;
        if (exmem_fwd_b) begin
            fwd_b = EXMEM_ALU_Result;
        end else if (memwb_fwd_b) begin
            fwd_b = MEMWB_WriteData;
        end
    end

    // ------------------------------------------------------------------
    // Operand select. Shifts by shamt take the value to shift from rt, so
    // operand 1 becomes forwarded B and operand 2 the zero-extended shamt.
    // Store data is always forwarded B, even when ALUSrc picks the
    // immediate for the address computation.
    // ------------------------------------------------------------------
    always_comb begin
        ALU_In1 = fwd_a;
        ALU_In2 = fwd_b;
        if (ex_shiftsrc) begin
            ALU_In1 = fwd_b;
            ALU_In2 = {27'd0, ex_shamt};
        end else if (ex_alusrc) begin
            ALU_In2 = ex_imm;
        end
    end

    assign EX_StoreData = fwd_b;
    assign ALU_Control  = ex_alu_control;
    assign EX_Rd        = ex_rd;
    assign EX_Valid     = ex_valid;
    assign EX_RegWrite  = ex_regwrite;
    assign EX_MemRead   = ex_memread;
    assign EX_MemWrite  = ex_memwrite;
    assign EX_MemToReg  = ex_memtoreg;
    assign Stall        = stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Bench for id_ex_stage: directed cases for the worked examples, then
// randomized traffic over a small register range so hazards and forwarding
// matches are frequent. The reference model keeps the instruction occupying
// EX as a record in a one-deep expected queue and derives every output from
// that record plus the live forwarding inputs.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        id_valid;
    logic [31:0] id_rd1, id_rd2, id_imm;
    logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
    logic [3:0]  id_alu;
    logic        id_alusrc, id_shiftsrc, id_regdst;
    logic        id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic        flush;
    logic        exmem_rw;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_res;
    logic        memwb_rw;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;

    logic [31:0] alu_in1, alu_in2, ex_store;
    logic [3:0]  alu_ctrl;
    logic [4:0]  ex_rd;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
    logic        stall;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ID_Valid(id_valid), .ID_ReadData1(id_rd1), .ID_ReadData2(id_rd2),
        .ID_SignExtImm(id_imm), .ID_Shamt(id_shamt),
        .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_Rd(id_rd),
        .ID_ALU_Control(id_alu), .ID_ALUSrc(id_alusrc), .ID_ShiftSrc(id_shiftsrc),
        .ID_RegDst(id_regdst), .ID_RegWrite(id_regwrite), .ID_MemRead(id_memread),
        .ID_MemWrite(id_memwrite), .ID_MemToReg(id_memtoreg),
        .Flush(flush),
        .EXMEM_RegWrite(exmem_rw), .EXMEM_Rd(exmem_rd), .EXMEM_ALU_Result(exmem_res),
        .MEMWB_RegWrite(memwb_rw), .MEMWB_Rd(memwb_rd), .MEMWB_WriteData(memwb_data),
        .ALU_In1(alu_in1), .ALU_In2(alu_in2), .ALU_Control(alu_ctrl),
        .EX_StoreData(ex_store), .EX_Rd(ex_rd), .EX_Valid(ex_valid),
        .EX_RegWrite(ex_regwrite), .EX_MemRead(ex_memread), .EX_MemWrite(ex_memwrite),
        .EX_MemToReg(ex_memtoreg), .Stall(stall)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        valid, regwrite, memread, memwrite, memtoreg;
        logic        alusrc, shiftsrc;
        logic [3:0]  alu;
        logic [4:0]  dest, rs, rt, shamt;
        logic [31:0] d1, d2, imm;
    } ex_t;

    localparam ex_t BUBBLE = '0;

    ex_t exp_q[$];          // instruction expected to occupy EX (one deep)

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Value of a source register seen in EX: newest writer wins, $0 never.
    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] regfile_val);
        if (exmem_rw && r != 0 && r == exmem_rd) return exmem_res;
        if (memwb_rw && r != 0 && r == memwb_rd) return memwb_data;
        return regfile_val;
    endfunction

    function automatic logic hazard_exp(input ex_t cur);
        return cur.valid && cur.memread && cur.dest != 0 && id_valid &&
               (cur.dest == id_rs || cur.dest == id_rt);
    endfunction

    task automatic compare_all();
        ex_t cur;
        logic [31:0] a, b, in1, in2;
        cur = exp_q[0];
        a   = operand(cur.rs, cur.d1);
        b   = operand(cur.rt, cur.d2);
        in1 = cur.shiftsrc ? b : a;
        in2 = cur.shiftsrc ? {27'd0, cur.shamt} : (cur.alusrc ? cur.imm : b);
        check("alu_in1",  alu_in1, in1);
        check("alu_in2",  alu_in2, in2);
        check("store",    ex_store, b);
        check("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, cur.alu});
        check("ex_rd",    {27'd0, ex_rd}, {27'd0, cur.dest});
        check("ctrls",    {27'd0, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg},
                          {27'd0, cur.valid, cur.regwrite, cur.memread, cur.memwrite, cur.memtoreg});
        check("stall",    {31'd0, stall}, {31'd0, hazard_exp(cur)});
    endtask

    // Called at a negedge with inputs driven: check, clock once, return at negedge.
    task automatic step();
        ex_t nxt;
        #1;
        compare_all();
        if (flush || hazard_exp(exp_q[0]) || !id_valid) begin
            nxt = BUBBLE;
        end else begin
            nxt = '{valid: 1'b1, regwrite: id_regwrite, memread: id_memread,
                    memwrite: id_memwrite, memtoreg: id_memtoreg, alusrc: id_alusrc,
                    shiftsrc: id_shiftsrc, alu: id_alu,
                    dest: id_regdst ? id_rd : id_rt, rs: id_rs, rt: id_rt,
                    shamt: id_shamt, d1: id_rd1, d2: id_rd2, imm: id_imm};
        end
        exp_q.push_back(nxt);
        @(posedge clk);
        void'(exp_q.pop_front());
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_fwd();
        exmem_rw = 0; exmem_rd = 0; exmem_res = 0;
        memwb_rw = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    task automatic drive_id(input logic [3:0] alu, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2);
        id_valid = 1; id_alu = alu; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rd1 = d1; id_rd2 = d2; id_imm = 0; id_shamt = 0;
        id_alusrc = 0; id_shiftsrc = 0; id_regdst = 1;
        id_regwrite = 1; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
        flush = 0;
    endtask

    task automatic randomize_inputs();
        id_valid    = ($urandom_range(0, 9) < 8);
        id_rd1      = $urandom;  id_rd2 = $urandom;  id_imm = $urandom;
        id_shamt    = 5'($urandom_range(0, 31));
        id_rs       = 5'($urandom_range(0, 3));
        id_rt       = 5'($urandom_range(0, 3));
        id_rd       = 5'($urandom_range(0, 3));
        id_alu      = 4'($urandom_range(0, 9));
        id_alusrc   = 1'($urandom_range(0, 1));
        id_shiftsrc = 1'($urandom_range(0, 1));
        id_regdst   = 1'($urandom_range(0, 1));
        id_regwrite = 1'($urandom_range(0, 1));
        id_memread  = ($urandom_range(0, 9) < 3);
        id_memwrite = 1'($urandom_range(0, 1));
        id_memtoreg = 1'($urandom_range(0, 1));
        flush       = ($urandom_range(0, 9) == 0);
        exmem_rw    = 1'($urandom_range(0, 1));
        exmem_rd    = 5'($urandom_range(0, 3));
        exmem_res   = $urandom;
        memwb_rw    = 1'($urandom_range(0, 1));
        memwb_rd    = 5'($urandom_range(0, 3));
        memwb_data  = $urandom;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        exp_q = {BUBBLE};
        drive_id(4'd1, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2);
        id_valid = 0;
        clear_fwd();
        repeat (2) @(negedge clk);
        #1;
        compare_all();                       // state under reset
        @(negedge clk);
        rst_n = 1;

        // ADD rs=$1 (5), rt=$2 (7), rd=$5
        drive_id(4'd1, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7);
        step();
        #1;
        check("add_in1",  alu_in1, 32'd5);
        check("add_in2",  alu_in2, 32'd7);
        check("add_ctrl", {28'd0, alu_ctrl}, 32'd1);
        check("add_rd",   {27'd0, ex_rd}, 32'd5);

        // Forward priority and register-0 exclusion on rs=$1
        drive_id(4'd2, 5'd1, 5'd2, 5'd6, 32'd99, 32'd7);
        step();
        exmem_rw = 1; exmem_rd = 1; exmem_res = 32'h10;
        memwb_rw = 1; memwb_rd = 1; memwb_data = 32'h20;
        #1 check("fwd_both_exmem", alu_in1, 32'h10);
        exmem_rd = 0;
        #1 check("fwd_r0_to_memwb", alu_in1, 32'h20);
        memwb_rw = 0;
        #1 check("fwd_none", alu_in1, 32'd99);
        clear_fwd();

        // LW $3 then a consumer of $3 in rt
        drive_id(4'd1, 5'd0, 5'd3, 5'd0, 32'd100, 32'd0);
        id_regdst = 0; id_memread = 1; id_memtoreg = 1; id_alusrc = 1; id_imm = 32'd4;
        step();
        drive_id(4'd1, 5'd5, 5'd3, 5'd7, 32'd1, 32'd555);
        #1 check("lu_stall", {31'd0, stall}, 32'd1);
        step();
        #1;
        check("lu_bubble", {31'd0, ex_valid}, 32'd0);
        check("lu_stall_drop", {31'd0, stall}, 32'd0);
        step();
        memwb_rw = 1; memwb_rd = 3; memwb_data = 32'hDEAD;
        #1 check("lu_memwb_fwd", alu_in2, 32'hDEAD);
        clear_fwd();

        // SLL rt=$4 (1), shamt=4
        drive_id(4'd3, 5'd0, 5'd4, 5'd8, 32'd0, 32'd1);
        id_shiftsrc = 1; id_shamt = 5'd4;
        step();
        #1;
        check("sll_in1",  alu_in1, 32'd1);
        check("sll_in2",  alu_in2, 32'd4);
        check("sll_ctrl", {28'd0, alu_ctrl}, 32'd3);

        // SW imm=8, rt=$6 forwarded from EX/MEM
        drive_id(4'd1, 5'd2, 5'd6, 5'd0, 32'd0, 32'd0);
        id_alusrc = 1; id_imm = 32'd8; id_regwrite = 0; id_memwrite = 1; id_regdst = 0;
        step();
        exmem_rw = 1; exmem_rd = 6; exmem_res = 32'hAB;
        #1;
        check("sw_in2",   alu_in2, 32'd8);
        check("sw_store", ex_store, 32'hAB);
        clear_fwd();

        // Flush with a valid instruction in ID
        drive_id(4'd1, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2);
        flush = 1;
        step();
        #1 check("flush_bubble", {31'd0, ex_valid}, 32'd0);
        flush = 0;
        step();
        #1 check("flush_then_valid", {31'd0, ex_valid}, 32'd1);

        // Asynchronous reset mid-cycle
        #2 rst_n = 0;
        exp_q = {BUBBLE};
        #1 compare_all();
        @(negedge clk);
        rst_n = 1;

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 ID_Valid  in  1  decode stage holds a real instruction.
REQ-005 ID_ReadData1, ID_ReadData2  in  32 each  register-file values for rs, rt.
REQ-006 ID_SignExtImm  in  32  sign-extended immediate.
REQ-007 ID_Shamt  in  5  shift amount field.
REQ-008 ID_Rs, ID_Rt, ID_Rd  in  5 each  register specifiers.
REQ-009 ID_ALU_Control  in  4  ALU opcode: 1 ADD, 2 SUB, 3 SLL, 4 SRL, 5 AND, 6 OR, 7 NOR, 8 SLTU, 9 SLT.
REQ-010 ID_ALUSrc, ID_ShiftSrc, ID_RegDst  in  1 each  immediate operand select; shift-by-shamt select; destination = rd (1) or rt (0).
REQ-011 ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg  in  1 each  downstream control.
REQ-012 Flush  in  1  squash the instruction entering EX (taken branch/jump).
REQ-013 EXMEM_RegWrite, EXMEM_Rd, EXMEM_ALU_Result  in  1/5/32  forwarding source 1.
REQ-014 MEMWB_RegWrite, MEMWB_Rd, MEMWB_WriteData  in  1/5/32  forwarding source 2.
REQ-015 ALU_In1, ALU_In2  out  32 each  ALU operands (InputData1, InputData2).
REQ-016 ALU_Control  out  4  registered ALU opcode.
REQ-017 EX_StoreData  out  32  forwarded rt value for stores.
REQ-018 EX_Rd  out  5  registered destination register.
REQ-019 EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg  out  1 each  registered controls.
REQ-020 Stall  out  1  combinational load-use hazard; upstream holds PC and IF/ID.

Function
REQ-021 Each rising edge with Stall=0 and Flush=0 SHALL latch all ID_* fields; EX_Rd = ID_RegDst ? ID_Rd : ID_Rt; latency ID to ALU inputs = 1 cycle.
REQ-022 Edge with Stall=1 or Flush=1 SHALL load a bubble: EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg = 0, ALU_Control = 0, EX_Rd = 0, data registers = 0.
REQ-023 ID_Valid=0 SHALL load a bubble identical to REQ-022.
REQ-024 Stall = EX_Valid & EX_MemRead & (EX_Rd != 0) & ID_Valid & (EX_Rd == ID_Rs | EX_Rd == ID_Rt); asserted exactly one cycle per load-use pair.
REQ-025 Forwarded A (rs) and B (rt): EXMEM_ALU_Result when EXMEM_RegWrite & EXMEM_Rd != 0 & EXMEM_Rd == registered rs/rt; else MEMWB_WriteData under same rule for MEMWB; else registered read data.
REQ-026 Both sources matching SHALL select EX/MEM (newest); register 0 SHALL never be forwarded.
REQ-027 ALU_In1 = ID_ShiftSrc(registered) ? forwarded B : forwarded A.
REQ-028 ALU_In2 = registered ShiftSrc ? {27'b0, shamt} : registered ALUSrc ? immediate : forwarded B.
REQ-029 EX_StoreData SHALL always equal forwarded B, independent of ALUSrc.
REQ-030 Forwarding and operand muxing SHALL be combinational from registered state and current forwarding inputs; no extra cycle.
REQ-031 Flush and Stall together SHALL produce one bubble; Flush has no effect on Stall output.

Reset
REQ-032 rst_n low SHALL immediately clear all registers to the bubble state of REQ-022, independent of clk.
REQ-033 Release of rst_n SHALL take effect on the first rising clk edge with rst_n high; reset mid-instruction discards it.
REQ-034 During reset Stall SHALL be 0 (EX_Valid=0).

Verification
REQ-035 ADD rs=$1 (5), rt=$2 (7), no hazards -> next cycle ALU_In1=5, ALU_In2=7, ALU_Control=1, EX_Rd=rd.
REQ-036 EXMEM_Rd=$1 result 0x10, MEMWB_Rd=$1 data 0x20, instr uses rs=$1 -> ALU_In1=0x10; EXMEM_Rd=$0 with RegWrite -> no forward.
REQ-037 LW $3 in EX, next ID uses rt=$3 -> Stall=1 one cycle, bubble enters EX (EX_Valid=0), instruction enters next cycle with MEMWB forward of load data.
REQ-038 SLL rt=$4 (0x1), shamt=4, ShiftSrc=1 -> ALU_In1=0x1, ALU_In2=4, ALU_Control=3.
REQ-039 SW with ALUSrc=1, imm=8, rt forwarded from EX/MEM 0xAB -> ALU_In2=8, EX_StoreData=0xAB.
REQ-040 Flush=1 with valid ID, then rst_n pulsed low mid-cycle -> EX_Valid=0, all controls 0 immediately, no waiting for clk.
